// File: rtl/hack_cpu_ctrl.sv
// ============================================================================
// hack_cpu_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle control and register unit for the Hack CPU.
//
// Fetches 16-bit Hack instructions and holds the A, D and PC registers. It
// drives the control bits and operands of an external combinational Hack ALU
// and consumes the ALU result. Data memory is read and written through a
// req/ack handshake.
//
// Instruction flow (FSM):
//   FETCH  -> DECODE                    on imem_ack
//   DECODE -> FETCH                     A-instruction (commits in DECODE)
//   DECODE -> MEMRD                     C-instruction with comp using M
//   DECODE -> EXEC                      C-instruction with comp using A
//   MEMRD  -> EXEC                      on dmem_ack
//   EXEC   -> MEMWR                     dest includes M
//   EXEC   -> FETCH                     otherwise (commits in EXEC)
//   MEMWR  -> FETCH                     on dmem_ack (commits in MEMWR)
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req/addr/rdata/ack    instruction fetch port (addr = PC)
//   dmem_req/we/addr/wdata/    data memory port (addr = A[14:0],
//   dmem_rdata/ack               wdata = ALU result latch R)
//   alu_x, alu_y               ALU operands (x = D, y = IR[12] ? M : A)
//   alu_zx..alu_no             ALU control bits = IR[11:6]
//   alu_out                    ALU result (combinational from alu_*)
//   pc, a_reg, d_reg           architectural register views
//   instr_done                 one-cycle pulse in the cycle that commits
// ============================================================================
module hack_cpu_ctrl (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,

    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,

    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMWR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_ir;      // current instruction
    logic [15:0] r_a;       // A register
    logic [15:0] r_d;       // D register
    logic [14:0] r_pc;      // program counter
    logic [15:0] r_m;       // latched data-memory read value
    logic [15:0] r_r;       // latched ALU result
    logic        r_taken;   // jump decision latched in EXEC for a MEMWR commit

    // Instruction field decode (C-instruction layout: 111a cccccc ddd jjj).
    logic        w_is_c;
    logic        w_comp_m;
    logic        w_dest_a;
    logic        w_dest_d;
    logic        w_dest_m;
    logic [2:0]  w_jmp;

    assign w_is_c   = r_ir[15];
    assign w_comp_m = r_ir[12];
    assign w_dest_a = r_ir[5];
    assign w_dest_d = r_ir[4];
    assign w_dest_m = r_ir[3];
    assign w_jmp    = r_ir[2:0];

    // Jump condition from the live ALU result (meaningful only in EXEC).
    logic        w_zr;
    logic        w_ng;
    logic        w_jump;

    assign w_zr   = (alu_out == 16'h0000);
    assign w_ng   = alu_out[15];
    assign w_jump = (w_jmp[2] & w_ng) | (w_jmp[1] & w_zr) | (w_jmp[0] & ~w_ng & ~w_zr);

    // PC+1 is 15 bits wide, so 0x7FFF wraps to 0x0000 naturally.
    logic [14:0] w_pc_inc;
    assign w_pc_inc = r_pc + 15'd1;

    // Commit data: in EXEC the result is still on alu_out (R is being loaded
    // on the same edge); in MEMWR it comes from the latched copies.
    logic        w_commit;
    logic [15:0] w_commit_val;
    logic        w_commit_taken;

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset is in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches for every path through the case statement.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_is_c) begin
                    w_next_state = S_FETCH;
                end else if (w_comp_m) begin
                    w_next_state = S_MEMRD;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_MEMRD: begin
                if (dmem_ack) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = w_dest_m ? S_MEMWR : S_FETCH;
            end
            S_MEMWR: begin
                if (dmem_ack) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs and commit controls
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req       = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        instr_done     = 1'b0;
        w_commit       = 1'b0;
        w_commit_val   = r_r;
        w_commit_taken = r_taken;
        case (r_state)
            S_FETCH: begin
                // Reset parks the FSM in FETCH; hold the request low until
                // reset is released so no fetch is issued during reset.
                imem_req = ~rst;
            end
            S_DECODE: begin
                instr_done = ~w_is_c;
            end
            S_MEMRD: begin
                dmem_req = 1'b1;
            end
            S_EXEC: begin
                w_commit       = ~w_dest_m;
                instr_done     = ~w_dest_m;
                w_commit_val   = alu_out;
                w_commit_taken = w_jump;
            end
            S_MEMWR: begin
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                w_commit   = dmem_ack;
                instr_done = dmem_ack;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= 16'h0000;
            r_a     <= 16'h0000;
            r_d     <= 16'h0000;
            r_pc    <= 15'h0000;
            r_m     <= 16'h0000;
            r_r     <= 16'h0000;
            r_taken <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_rdata;
                    end
                end
                S_DECODE: begin
                    if (!w_is_c) begin
                        r_a  <= {1'b0, r_ir[14:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                S_MEMRD: begin
                    if (dmem_ack) begin
                        r_m <= dmem_rdata;
                    end
                end
                S_EXEC: begin
                    r_r     <= alu_out;
                    r_taken <= w_jump;
                end
                default: begin
                end
            endcase

            // Commit. The jump target reads r_a before this edge, so an
            // instruction that both writes A and jumps uses the old A.
            if (w_commit) begin
                if (w_dest_a) begin
                    r_a <= w_commit_val;
                end
                if (w_dest_d) begin
                    r_d <= w_commit_val;
                end
                r_pc <= w_commit_taken ? r_a[14:0] : w_pc_inc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------------
    assign imem_addr  = r_pc;
    assign dmem_addr  = r_a[14:0];
    assign dmem_wdata = r_r;

    assign alu_x  = r_d;
    assign alu_y  = w_comp_m ? r_m : r_a;
    assign alu_zx = r_ir[11];
    assign alu_nx = r_ir[10];
    assign alu_zy = r_ir[9];
    assign alu_ny = r_ir[8];
    assign alu_f  = r_ir[7];
    assign alu_no = r_ir[6];

    assign pc    = r_pc;
    assign a_reg = r_a;
    assign d_reg = r_d;

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle control and register unit for the Hack CPU. It fetches 16-bit Hack instructions, holds the A, D and PC registers, and drives the control inputs and operands of the external 16-bit combinational Hack ALU. It also reads and writes data memory through a req/ack handshake. It sits between the instruction and data memory ports and the ALU, generating the zx/nx/zy/ny/f/no controls and consuming the ALU result.

## Interface
Parameters: none (16-bit data and 15-bit addresses are fixed by the Hack ISA).

Clock and reset are decided: one clock; reset is asynchronous and active-high.

- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address (= PC)
- imem_rdata  in  16  instruction word; valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  15  data address (= A[14:0])
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data; valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- alu_x  out  16  ALU x operand (= D)
- alu_y  out  16  ALU y operand (= M latch if IR[12], else A)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  = IR[11], IR[10], IR[9], IR[8], IR[7], IR[6]
- alu_out  in  16  ALU result, combinational from the alu_* outputs
- pc  out  15  program counter
- a_reg  out  16  A register
- d_reg  out  16  D register
- instr_done  out  1  one-cycle pulse on instruction commit

## Operation
- **States:** FETCH, DECODE, MEMRD, EXEC, MEMWR.
- **FETCH**
  - imem_req=1, imem_addr=pc, held stable until imem_ack is sampled high.
  - On ack: IR<=imem_rdata, then go to DECODE.
- **DECODE**
  - If IR[15]=0 (A-instruction): A<={1'b0, IR[14:0]}, PC<=PC+1, instr_done=1, then FETCH.
  - If IR[15]=1 (C-instruction): go to MEMRD if IR[12]=1, else EXEC.
- **MEMRD**
  - dmem_req=1, dmem_we=0, dmem_addr=A[14:0].
  - On ack: M<=dmem_rdata, then EXEC.
- **EXEC**
  - R<=alu_out.
  - zr = (alu_out==0); ng = alu_out[15].
  - Jump taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - If IR[3] (dest M): go to MEMWR. Otherwise commit, then FETCH.
- **MEMWR**
  - dmem_req=1, dmem_we=1, dmem_addr=A[14:0], dmem_wdata=R.
  - On ack: commit, then FETCH.
- **Commit** (all in one edge):
  - If IR[5]: A<=R.
  - If IR[4]: D<=R.
  - PC<=taken ? A[14:0] : PC+1.
  - instr_done=1.
- **Old-A rule:** the jump target and the M address always use A as it was before commit, including when the instruction also writes A.
- **PC wrap:** PC+1 wraps 0x7FFF -> 0x0000.
- **Requests outside their states:** imem_req=0 outside FETCH; dmem_req=0 outside MEMRD/MEMWR. Acks received while the matching req is low are ignored.
- **Opcode bits:** IR[14:13] are don't-care.

## Timing
- **Reset values:** state=FETCH, PC=0, A=0, D=0, IR=0, M=0, R=0.
  - All req/we/instr_done outputs are 0 while rst is high.
  - alu_* control outputs are 0, since IR=0.
- **Reset mid-access:** asserting rst during any state clears everything immediately, without waiting for the clock. A pending req drops in the same cycle and the access is abandoned.
  - On the first edge after rst deasserts, imem_req=1 with imem_addr=0.
- **Handshake:** ack is sampled on the rising edge while req=1. Zero-wait is allowed: ack high in the first req cycle completes the access at that edge.
  - addr, we and wdata are stable for the whole req window.
- **Latency** (cycles, zero-wait memory, FETCH to next FETCH):
  - A-instruction: 2.
  - C-instruction, no M: 3.
  - Plus 1 if the comp field uses M (IR[12]=1).
  - Plus 1 if the dest field includes M (IR[3]=1).
  - Plus N for each access acked after N wait cycles.
- **Combinational ALU:** alu_out is combinational from the alu_* outputs and is used only in EXEC.

## Test plan
- **A-instruction:** rst, then fetch 0x0005 with zero-wait ack.
  - Required: A=5 and PC=1.
  - instr_done pulses 2 cycles after reset release.
- **D=A:** 0x0005, then 0xEC10.
  - Required: D=5, PC=2, no dmem_req in either instruction.
- **M=D+1:** A=5, D=5, then 0xE7C8.
  - Required: dmem write with addr=5, wdata=6, we=1.
  - D unchanged; PC increments after ack.
- **D=D+M with slow memory:** A=5, D=5, then 0xF090; dmem_ack delayed 3 cycles with rdata=10.
  - Required: dmem_req and addr held high/stable for 4 cycles, then D=15.
- **Jumps:**
  - A=100, D=0, then 0xEA82 (0;JEQ): PC=100.
  - A=100, D=0xFFFF, then 0xE301 (D;JGT): not taken, PC=old PC+1.
  - PC=0x7FFF with an A-instruction: PC wraps to 0.
- **Reset mid-MEMRD:** assert rst while dmem_req=1.
  - Required: dmem_req=0 in the same cycle; PC=A=D=0.
  - The next fetch is from address 0.
